// File: rtl/weight_bias_loader.sv
// Weight/bias configuration loader: parses header + payload packets from a
// valid/ready stream and strobes weight or bias words to the network layers.
module weight_bias_loader #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned MAX_WORDS  = 784
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic [31:0] weightValue,
  output logic        weightValid,
  output logic [31:0] biasValue,
  output logic        biasValid,
  output logic        busy,
  output logic        pkt_done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned CNT_W = 15;

  typedef enum logic [1:0] {HDR, LOAD, DRAIN, COMMIT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_bias_q;

  logic               xfer;
  logic [7:0]         hdr_layer;
  logic [7:0]         hdr_neuron;
  logic               hdr_is_bias;
  logic [CNT_W-1:0]   hdr_n;
  logic               bad_layer;
  logic               bad_count;
  logic               bad_bias;
  logic               hdr_bad;
  logic [1:0]         hdr_code;

  // Ready in every state but COMMIT; forced low while reset is asserted.
  assign s_ready = ~reset & (state != COMMIT);
  assign xfer    = s_valid & s_ready;

  assign hdr_layer   = s_data[31:24];
  assign hdr_neuron  = s_data[23:16];
  assign hdr_is_bias = s_data[15];
  assign hdr_n       = s_data[14:0];

  assign bad_layer = (hdr_layer == 8'd0) || (32'(hdr_layer) > NUM_LAYERS);
  assign bad_count = (hdr_n == '0) || (32'(hdr_n) > MAX_WORDS);
  assign bad_bias  = hdr_is_bias && (hdr_n != CNT_W'(1));
  assign hdr_bad   = bad_layer | bad_count | bad_bias;

  // First-error cause with layer > count > bias precedence.
  always_comb begin
    hdr_code = 2'd3;
    if (bad_layer)      hdr_code = 2'd1;
    else if (bad_count) hdr_code = 2'd2;
  end

  // Packet FSM with registered strobes, config address and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= HDR;
      cnt               <= '0;
      is_bias_q         <= 1'b0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      weightValue       <= '0;
      weightValid       <= 1'b0;
      biasValue         <= '0;
      biasValid         <= 1'b0;
      busy              <= 1'b0;
      pkt_done          <= 1'b0;
      err               <= 1'b0;
      err_code          <= 2'd0;
    end else begin
      weightValid <= 1'b0;
      biasValid   <= 1'b0;
      pkt_done    <= 1'b0;
      case (state)
        HDR: begin
          if (xfer) begin
            cnt  <= hdr_n;
            busy <= 1'b1;
            if (hdr_bad) begin
              err <= 1'b1;
              if (!err) err_code <= hdr_code;
              state <= (hdr_n == '0) ? COMMIT : DRAIN;
            end else begin
              config_layer_num  <= 32'(hdr_layer);
              config_neuron_num <= 32'(hdr_neuron);
              is_bias_q         <= hdr_is_bias;
              state             <= LOAD;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            if (is_bias_q) begin
              biasValue <= s_data;
              biasValid <= 1'b1;
            end else begin
              weightValue <= s_data;
              weightValid <= 1'b1;
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= COMMIT;
          end
        end
        DRAIN: begin
          if (xfer) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= COMMIT;
          end
        end
        COMMIT: begin
          pkt_done <= 1'b1;
          busy     <= 1'b0;
          state    <= HDR;
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_bias_loader.sv
// Scoreboard bench for weight_bias_loader: the driver queues expected strobes
// as it issues transfers, a negedge monitor pops and compares them.
module tb_weight_bias_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic [31:0] weightValue;
  logic        weightValid;
  logic [31:0] biasValue;
  logic        biasValid;
  logic        busy;
  logic        pkt_done;
  logic        err;
  logic [1:0]  err_code;

  weight_bias_loader #(.NUM_LAYERS(4), .MAX_WORDS(784)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .config_layer_num(config_layer_num),
    .config_neuron_num(config_neuron_num), .weightValue(weightValue),
    .weightValid(weightValid), .biasValue(biasValue), .biasValid(biasValid),
    .busy(busy), .pkt_done(pkt_done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int asserts = 0;
  int fails   = 0;

  // kind: 0 = weight strobe, 1 = bias strobe, 2 = pkt_done
  typedef struct {
    int          kind;
    logic [31:0] val;
    int          at;
    logic [31:0] lay;
    logic [31:0] neu;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_event(input int kind, input logic [31:0] val);
    exp_t e;
    asserts++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: kind %0d value 0x%08h at cycle %0d, none expected", kind, val, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.at != cyc ||
          (kind < 2 && (val !== e.val || config_layer_num !== e.lay || config_neuron_num !== e.neu))) begin
        fails++;
        $display("FAIL event: got kind %0d val 0x%08h cyc %0d layer %0d neuron %0d, expected kind %0d val 0x%08h cyc %0d layer %0d neuron %0d",
                 kind, val, cyc, config_layer_num, config_neuron_num, e.kind, e.val, e.at, e.lay, e.neu);
      end
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (weightValid && biasValid) begin
      asserts++;
      fails++;
      $display("FAIL both_strobes: weightValid=1 biasValid=1 at cycle %0d, required at most one", cyc);
    end
    if (weightValid) check_event(0, weightValue);
    if (biasValid)   check_event(1, biasValue);
    if (pkt_done)    check_event(2, 32'h0);
  end

  // Drive one word (called at a negedge); waits for s_ready, queues expected
  // strobe (kind >= 0) and, for the last word of a packet, the pkt_done.
  task automatic send(input logic [31:0] w, input int kind, input logic [31:0] lay,
                      input logic [31:0] neu, input bit last);
    int waits = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && waits <= 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits > 50) begin
      asserts++;
      fails++;
      $display("FAIL send_timeout: s_ready stayed 0 for word 0x%08h, required 1", w);
    end else begin
      if (kind >= 0) q.push_back('{kind, w, cyc + 1, lay, neu});
      if (last)      q.push_back('{2, 32'h0, cyc + 2, 32'h0, 32'h0});
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"},     32'(s_ready), 32'h0);
    chk({tag, "_weightValid"}, 32'(weightValid), 32'h0);
    chk({tag, "_biasValid"},   32'(biasValid), 32'h0);
    chk({tag, "_pkt_done"},    32'(pkt_done), 32'h0);
    chk({tag, "_busy"},        32'(busy), 32'h0);
    chk({tag, "_err"},         32'(err), 32'h0);
    chk({tag, "_err_code"},    32'(err_code), 32'h0);
    chk({tag, "_layer"},       config_layer_num, 32'h0);
    chk({tag, "_neuron"},      config_neuron_num, 32'h0);
    chk({tag, "_weightValue"}, weightValue, 32'h0);
    chk({tag, "_biasValue"},   biasValue, 32'h0);
  endtask

  task automatic pulse_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(s_ready), 32'h1);
    chk("busy_idle", 32'(busy), 32'h0);

    // Weight packet layer 1 neuron 3, three words back-to-back.
    send(32'h0103_0003, -1, 0, 0, 1'b0);
    chk("t1_layer", config_layer_num, 32'd1);
    chk("t1_neuron", config_neuron_num, 32'd3);
    chk("t1_busy", 32'(busy), 32'h1);
    send(32'hA000_000A, 0, 32'd1, 32'd3, 1'b0);
    send(32'hB000_000B, 0, 32'd1, 32'd3, 1'b0);
    send(32'hC000_000C, 0, 32'd1, 32'd3, 1'b1);
    idle(3);
    chk("t1_busy_after", 32'(busy), 32'h0);
    chk("t1_layer_hold", config_layer_num, 32'd1);

    // Bias packet layer 2 neuron 2.
    send(32'h0202_8001, -1, 0, 0, 1'b0);
    send(32'h0000_0100, 1, 32'd2, 32'd2, 1'b1);
    idle(3);
    chk("t2_weight_hold", weightValue, 32'hC000_000C);
    chk("t2_bias_hold", biasValue, 32'h0000_0100);

    // Weight packet N=4 with bubbles between words.
    send(32'h0304_0004, -1, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(32'h1111_0000 + 32'(i), 0, 32'd3, 32'd4, i == 3);
      chk("t3_busy_xfer", 32'(busy), 32'h1);
      if (i < 3) begin
        idle(1);
        chk("t3_busy_bubble", 32'(busy), 32'h1);
      end
    end
    idle(3);

    // Bad layer 5: drained, then a good packet still loads.
    send(32'h0500_0002, -1, 0, 0, 1'b0);
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_err_code", 32'(err_code), 32'd1);
    chk("t4_layer_unchanged", config_layer_num, 32'd3);
    chk("t4_neuron_unchanged", config_neuron_num, 32'd4);
    send(32'h5555_5555, -1, 0, 0, 1'b0);
    send(32'h6666_6666, -1, 0, 0, 1'b1);
    idle(2);
    send(32'h0401_0002, -1, 0, 0, 1'b0);
    send(32'h7777_0001, 0, 32'd4, 32'd1, 1'b0);
    send(32'h7777_0002, 0, 32'd4, 32'd1, 1'b1);
    idle(3);
    chk("t4_err_sticky", 32'(err), 32'h1);
    chk("t4_code_sticky", 32'(err_code), 32'd1);
    chk("t4_good_layer", config_layer_num, 32'd4);

    // Bias count error, then a count error that must not overwrite the code.
    pulse_reset();
    send(32'h0100_8002, -1, 0, 0, 1'b0);
    chk("t5_err", 32'(err), 32'h1);
    chk("t5_err_code", 32'(err_code), 32'd3);
    send(32'h8888_0001, -1, 0, 0, 1'b0);
    send(32'h8888_0002, -1, 0, 0, 1'b1);
    send(32'h0100_0000, -1, 0, 0, 1'b1);
    idle(3);
    chk("t5_code_kept", 32'(err_code), 32'd3);
    chk("t5_busy", 32'(busy), 32'h0);

    // Reset after 2 of 5 words abandons the packet.
    send(32'h0102_0005, -1, 0, 0, 1'b0);
    send(32'h9999_0001, 0, 32'd1, 32'd2, 1'b0);
    send(32'h9999_0002, 0, 32'd1, 32'd2, 1'b0);
    reset   = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    @(negedge clk);
    send(32'h0201_0001, -1, 0, 0, 1'b0);
    chk("t6_hdr_layer", config_layer_num, 32'd2);
    chk("t6_hdr_neuron", config_neuron_num, 32'd1);
    send(32'h0000_ABCD, 0, 32'd2, 32'd1, 1'b1);
    idle(4);

    asserts++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected events never seen, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
